pc_sequencer: RTL

//   4-bit program-counter sequencer for the fetch path. Holds the current PC.

---
 rtl/pc_sequencer_pkg.sv | 14 +
 rtl/pc_sequencer_adder.sv | 13 +
 rtl/pc_sequencer.sv | 106 ++++++++++
 3 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the fetch-path program-counter sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pc_sequencer_pkg;

    localparam int PC_W = 4;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

endpackage

// File: rtl/pc_sequencer_adder.sv
// Add-by-one incrementer producing the next sequential PC.
// Latency: combinational.
// Backpressure: none; the carry-out is dropped so the PC wraps modulo 2^PC_W.
module add_by_one_adder
    import pc_sequencer_pkg::*;
(
    input  logic [PC_W-1:0] a,
    output logic [PC_W-1:0] s
);

    assign s = a + {{(PC_W-1){1'b0}}, 1'b1};

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: issues pc to fetch, handles branch redirect, stall and wrap.
// Latency: pc advances on the edge after an accept; wrap/redirected pulse the cycle after.
// Backpressure: pc is held stable while fetch_valid & !fetch_ready; stall gates fetch_valid.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 4'h0,
    parameter logic [PC_W-1:0] LAST_PC  = 4'hF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_en,
    input  logic [PC_W-1:0] branch_target,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [PC_W-1:0] pc,
    output logic            wrap,
    output logic            redirected
);

    state_t            state, state_nxt;
    logic [PC_W-1:0]   pc_nxt;
    logic [PC_W-1:0]   pc_plus1;
    logic              branch_pending, branch_pending_nxt;
    logic [PC_W-1:0]   pending_target, pending_target_nxt;
    logic              wrap_nxt, redirected_nxt;
    logic              accept;

    add_by_one_adder u_inc (
        .a (pc),
        .s (pc_plus1)
    );

    // Stall suppresses valid directly so a stalled ISSUE cycle can never be accepted.
    assign fetch_valid = (state == ST_ISSUE) && !stall;
    assign accept      = fetch_valid && fetch_ready;

    // State, pc, pending branch and pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_BOOT;
            pc             <= RESET_PC;
            branch_pending <= 1'b0;
            pending_target <= RESET_PC;
            wrap           <= 1'b0;
            redirected     <= 1'b0;
        end else begin
            state          <= state_nxt;
            pc             <= pc_nxt;
            branch_pending <= branch_pending_nxt;
            pending_target <= pending_target_nxt;
            wrap           <= wrap_nxt;
            redirected     <= redirected_nxt;
        end
    end

    // Next-state FSM plus prioritised next-pc mux (branch > pending > wrap > increment).
    always_comb begin
        state_nxt          = state;
        pc_nxt             = pc;
        branch_pending_nxt = branch_pending;
        pending_target_nxt = pending_target;
        wrap_nxt           = 1'b0;
        redirected_nxt     = 1'b0;

        case (state)
            ST_BOOT:  state_nxt = stall ? ST_HOLD : ST_ISSUE;
            ST_ISSUE: if (stall) state_nxt = ST_HOLD;
            ST_HOLD:  if (!stall) state_nxt = ST_ISSUE;
            default:  state_nxt = ST_BOOT;
        endcase

        if (accept) begin
            if (branch_en) begin
                pc_nxt             = branch_target;
                branch_pending_nxt = 1'b0;
                redirected_nxt     = 1'b1;
            end else if (branch_pending) begin
                pc_nxt             = pending_target;
                branch_pending_nxt = 1'b0;
                redirected_nxt     = 1'b1;
            end else if (pc == LAST_PC) begin
                pc_nxt   = RESET_PC;
                wrap_nxt = 1'b1;
            end else begin
                pc_nxt = pc_plus1;
            end
        end else if (branch_en) begin
            // pc is on the fetch bus in ISSUE, so a redirect must wait for the accept;
            // in BOOT/HOLD nothing is presented and the target can be loaded at once.
            if (state == ST_ISSUE) begin
                branch_pending_nxt = 1'b1;
                pending_target_nxt = branch_target;
            end else begin
                pc_nxt             = branch_target;
                branch_pending_nxt = 1'b0;
                redirected_nxt     = 1'b1;
            end
        end
    end

    param_order_a: assert property (@(posedge clk) LAST_PC >= RESET_PC);
    pulse_excl_a:  assert property (@(posedge clk) disable iff (!rst_n) !(wrap && redirected));

endmodule
